// File: rtl/loba_pkg.sv
// ============================================================================
// Module  : loba_pkg
// Brief   : Shared types and sizing helpers for the LOBA dot-product accumulator.
// Revision: 1.0
// ============================================================================
`default_nettype none

package loba_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } loba_state_e;

    localparam int LOBA_DEF_N     = 16;
    localparam int LOBA_DEF_GUARD = 8;

    function automatic int acc_width(input int n, input int guard);
        return 2 * n + guard;
    endfunction

    localparam int LOBA_DEF_ACC_W = acc_width(LOBA_DEF_N, LOBA_DEF_GUARD);

endpackage

`default_nettype wire

// File: rtl/loba_acc_add.sv
// ============================================================================
// Module  : loba_acc_add
// Brief   : Sign-extend a product, add to the accumulator, flag overflow and
//           clamp when LOBA_ACC_SAT_EN is defined (wrap-around otherwise).
// Revision: 1.0
// ============================================================================
`default_nettype none

module loba_acc_add #(
    parameter int N     = 16,
    parameter int GUARD = 8,
    parameter int ACC_W = 2 * N + GUARD
) (
    input  wire logic [ACC_W-1:0] acc,
    input  wire logic [2*N-1:0]   prod,
    output logic      [ACC_W-1:0] sum,
    output logic                  ovf
);

    localparam int PW = 2 * N;

    logic [ACC_W-1:0] w_prod_ext;
    logic [ACC_W:0]   w_wide;

    always_comb begin
        w_prod_ext = {{GUARD{prod[PW-1]}}, prod};
        // One extra bit keeps the true sign; disagreement with the next bit is overflow.
        w_wide     = {acc[ACC_W-1], acc} + {w_prod_ext[ACC_W-1], w_prod_ext};
        ovf        = w_wide[ACC_W] ^ w_wide[ACC_W-1];
    end

`ifdef LOBA_ACC_SAT_EN
    localparam logic [ACC_W-1:0] C_SAT_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] C_SAT_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    always_comb begin
        sum = w_wide[ACC_W-1:0];
        if (ovf) begin
            sum = w_wide[ACC_W] ? C_SAT_MIN : C_SAT_MAX;
        end
    end
`else
    always_comb begin
        sum = w_wide[ACC_W-1:0];
    end
`endif

endmodule

`default_nettype wire

// File: rtl/loba_dot_acc.sv
// ============================================================================
// Module  : loba_dot_acc
// Brief   : Burst dot-product accumulator for signed LOBA products with a
//           registered valid/ready result. Macro LOBA_ACC_SAT_EN selects clamp.
// Revision: 1.0
// ============================================================================
`default_nettype none

module loba_dot_acc
    import loba_pkg::*;
#(
    parameter int N     = 16,
    parameter int GUARD = 8,
    parameter int CNT_W = 16
) (
    input  wire logic                   clk,
    input  wire logic                   rst,
    input  wire logic                   clr,
    input  wire logic                   in_valid,
    output logic                        in_ready,
    input  wire logic [2*N-1:0]         in_prod,
    input  wire logic                   in_last,
    output logic                        out_valid,
    input  wire logic                   out_ready,
    output logic [2*N+GUARD-1:0]        out_sum,
    output logic [CNT_W-1:0]            out_count,
    output logic                        out_ovf
);

    localparam int ACC_W = acc_width(N, GUARD);

    loba_state_e       state_q, state_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ovf_q, ovf_d;
    logic              in_ready_q, in_ready_d;
    logic              out_valid_q, out_valid_d;
    logic [ACC_W-1:0]  out_sum_q, out_sum_d;
    logic [CNT_W-1:0]  out_count_q, out_count_d;
    logic              out_ovf_q, out_ovf_d;

    logic [ACC_W-1:0]  w_sum;
    logic              w_ovf;
    logic              w_beat;

    loba_acc_add #(
        .N     (N),
        .GUARD (GUARD),
        .ACC_W (ACC_W)
    ) u_add (
        .acc  (acc_q),
        .prod (in_prod),
        .sum  (w_sum),
        .ovf  (w_ovf)
    );

    assign w_beat = in_valid & in_ready_q;

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;
        out_sum_d   = out_sum_q;
        out_count_d = out_count_q;
        out_ovf_d   = out_ovf_q;

        if (clr) begin
            state_d     = ST_IDLE;
            acc_d       = '0;
            cnt_d       = '0;
            ovf_d       = 1'b0;
            out_valid_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_ACCUM: begin
                    if (w_beat) begin
                        acc_d = w_sum;
                        cnt_d = (cnt_q == {CNT_W{1'b1}}) ? cnt_q
                                : cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                        ovf_d = ovf_q | w_ovf;
                        if (in_last) begin
                            state_d     = ST_DONE;
                            out_valid_d = 1'b1;
                            out_sum_d   = w_sum;
                            out_count_d = cnt_d;
                            out_ovf_d   = ovf_d;
                        end else begin
                            state_d = ST_ACCUM;
                        end
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_d     = ST_IDLE;
                        acc_d       = '0;
                        cnt_d       = '0;
                        ovf_d       = 1'b0;
                        out_valid_d = 1'b0;
                    end
                end
                default: begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b0;
                end
            endcase
        end

        // Ready is a pure decode of the next state, so it carries no path from out_ready.
        in_ready_d = (state_d != ST_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_count_q <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
            out_count_q <= out_count_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_count = out_count_q;
    assign out_ovf   = out_ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_loba_dot_acc.sv
// ============================================================================
// Module  : tb_loba_dot_acc
// Brief   : Directed self-checking bench for loba_dot_acc (N=16, GUARD=1).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_loba_dot_acc;

    localparam int N     = 16;
    localparam int GUARD = 1;
    localparam int CNT_W = 16;
    localparam int ACC_W = 2 * N + GUARD;

    logic             clk = 1'b0;
    logic             rst;
    logic             clr;
    logic             in_valid;
    logic             in_ready;
    logic [2*N-1:0]   in_prod;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_sum;
    logic [CNT_W-1:0] out_count;
    logic             out_ovf;

    int checks   = 0;
    int failures = 0;

    loba_dot_acc #(
        .N     (N),
        .GUARD (GUARD),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_prod   (in_prod),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_count (out_count),
        .out_ovf   (out_ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Starts and ends on a falling edge; one rising edge in between.
    task automatic beat(input longint p, input logic l);
        check("beat_in_ready", 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        in_prod  = p[2*N-1:0];
        in_last  = l;
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic expect_result(input string tag, input longint s, input longint c, input logic o);
        check({tag, "_valid"}, 64'(out_valid), 64'd1);
        check({tag, "_sum"},   64'($signed(out_sum)), s);
        check({tag, "_count"}, 64'(out_count), c);
        check({tag, "_ovf"},   64'(out_ovf), 64'(o));
    endtask

    task automatic drain(input string tag);
        out_ready = 1'b1;
        @(negedge clk);
        check({tag, "_drained"}, 64'(out_valid), 64'd0);
        check({tag, "_ready_back"}, 64'(in_ready), 64'd1);
    endtask

    longint prods [12];
    longint exp_sum [3];

    initial begin
        rst = 1'b1; clr = 1'b0; in_valid = 1'b0; in_prod = '0; in_last = 1'b0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_sum",   64'(out_sum),   64'd0);
        check("rst_out_count", 64'(out_count), 64'd0);
        check("rst_out_ovf",   64'(out_ovf),   64'd0);
        check("rst_in_ready",  64'(in_ready),  64'd1);

        // Basic three-term vector, result one cycle after the last beat
        beat(100, 1'b0);
        beat(-30, 1'b0);
        beat(7, 1'b1);
        expect_result("vec3", 77, 3, 1'b0);
        check("vec3_in_ready_low", 64'(in_ready), 64'd0);
        drain("vec3");

        // Single beat held under back-pressure
        out_ready = 1'b0;
        beat(-5, 1'b1);
        for (int i = 0; i < 4; i++) begin
            expect_result("hold", -5, 1, 1'b0);
            check("hold_in_ready", 64'(in_ready), 64'd0);
            in_valid = 1'b1; in_prod = 32'd99; in_last = 1'b1;
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("hold_released", 64'(out_valid), 64'd0);
        check("hold_ready_back", 64'(in_ready), 64'd1);
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0;
        expect_result("after_hold", 99, 1, 1'b0);
        drain("after_hold");

        // Overflow with GUARD=1
        beat(64'h7FFF0000, 1'b0);
        beat(64'h7FFF0000, 1'b0);
        beat(64'h7FFF0000, 1'b1);
        check("ovf_flag", 64'(out_ovf), 64'd1);
`ifdef LOBA_ACC_SAT_EN
        check("ovf_sum", 64'(out_sum), 64'h0FFFFFFFF);
`else
        check("ovf_sum", 64'(out_sum), 64'h17FFD0000);
`endif
        drain("ovf");

        // Soft clear drops the coincident beat and the partial sum
        beat(10, 1'b0);
        beat(20, 1'b0);
        clr = 1'b1; in_valid = 1'b1; in_prod = 32'd30; in_last = 1'b1;
        @(negedge clk);
        clr = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        check("clr_no_valid", 64'(out_valid), 64'd0);
        check("clr_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        check("clr_no_valid2", 64'(out_valid), 64'd0);
        beat(1, 1'b1);
        expect_result("post_clr", 1, 1, 1'b0);
        drain("post_clr");

        // Asynchronous reset mid-vector, after a result left nonzero outputs
        beat(1234, 1'b1);
        out_ready = 1'b0;
        @(negedge clk);
        out_ready = 1'b1;
        #2 rst = 1'b1;
        #1;
        check("arst_valid", 64'(out_valid), 64'd0);
        check("arst_sum",   64'(out_sum),   64'd0);
        check("arst_count", 64'(out_count), 64'd0);
        #1 rst = 1'b0;
        @(negedge clk);
        beat(50, 1'b0);
        beat(60, 1'b0);
        #2 rst = 1'b1;
        #1;
        check("arst2_valid", 64'(out_valid), 64'd0);
        check("arst2_sum",   64'(out_sum),   64'd0);
        check("arst2_ovf",   64'(out_ovf),   64'd0);
        #1 rst = 1'b0;
        @(negedge clk);
        check("arst2_in_ready", 64'(in_ready), 64'd1);
        check("arst2_no_valid", 64'(out_valid), 64'd0);
        beat(3, 1'b1);
        expect_result("post_arst", 3, 1, 1'b0);
        drain("post_arst");

        // Back-to-back 4-term vectors, in_valid held high
        for (int v = 0; v < 3; v++) begin
            exp_sum[v] = 0;
            for (int t = 0; t < 4; t++) begin
                prods[v*4+t] = longint'($urandom_range(0, 65534)) - 32767;
                exp_sum[v] += prods[v*4+t];
            end
        end
        begin
            int idx = 0;
            int vec = 0;
            int cyc = 0;
            int last_cyc = 0;
            logic acc_ok;
            out_ready = 1'b1;
            while (vec < 3 && cyc < 60) begin
                if (out_valid) begin
                    expect_result("b2b", exp_sum[vec], 4, 1'b0);
                    if (vec > 0) check("b2b_period", 64'(cyc - last_cyc), 64'd5);
                    last_cyc = cyc;
                    vec++;
                end
                acc_ok = 1'b0;
                if (idx < 12) begin
                    in_valid = 1'b1;
                    in_prod  = prods[idx][2*N-1:0];
                    in_last  = (idx % 4 == 3);
                    acc_ok   = in_ready;
                end else begin
                    in_valid = 1'b0;
                    in_last  = 1'b0;
                end
                @(negedge clk);
                if (acc_ok) idx++;
                cyc++;
            end
            in_valid = 1'b0;
            check("b2b_vectors_seen", 64'(vec), 64'd3);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
